multicycle_controller: RTL and testbench

- Sequencing FSM for a multi-cycle RV32I datapath with one shared instruction/data memory, one ALU and a non-architectural register set (IR, OldPC, ALUOut, Data).
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.
- Each cycle it drives the mux selects and write enables. It handshakes with a memory that can stall.
- Replaces the single-cycle control path; the existing ALUDecoder is instantiated unchanged.

---
 rtl/multicycle_controller_pkg.sv | 77 +++++++
 rtl/multicycle_controller_alu_decoder.sv | 34 +++
 rtl/multicycle_controller.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: FSM state
// encoding, opcode constants and the datapath select encodings.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [3:0] ALUCTL_ADD  = 4'b0000;
    localparam logic [3:0] ALUCTL_SUB  = 4'b0001;
    localparam logic [3:0] ALUCTL_AND  = 4'b0010;
    localparam logic [3:0] ALUCTL_OR   = 4'b0011;
    localparam logic [3:0] ALUCTL_XOR  = 4'b0100;
    localparam logic [3:0] ALUCTL_SLT  = 4'b0101;
    localparam logic [3:0] ALUCTL_SLL  = 4'b0110;
    localparam logic [3:0] ALUCTL_SRL  = 4'b0111;
    localparam logic [3:0] ALUCTL_SRA  = 4'b1000;
    localparam logic [3:0] ALUCTL_SLTU = 4'b1001;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder carried over from the single-cycle control path.
// ALUOp selects add, sub or a funct3/funct7 decode of the instruction.
module ALUDecoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [3:0] ALUControl
);

    // Decode ALU operation; only R-type (op5=1) uses funct7b5 to pick sub.
    always_comb begin
        ALUControl = ALUCTL_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUCTL_ADD;
            ALUOP_SUB: ALUControl = ALUCTL_SUB;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 && funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
                    3'b001:  ALUControl = ALUCTL_SLL;
                    3'b010:  ALUControl = ALUCTL_SLT;
                    3'b011:  ALUControl = ALUCTL_SLTU;
                    3'b100:  ALUControl = ALUCTL_XOR;
                    3'b101:  ALUControl = funct7b5 ? ALUCTL_SRA : ALUCTL_SRL;
                    3'b110:  ALUControl = ALUCTL_OR;
                    default: ALUControl = ALUCTL_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath (shared memory, one ALU).
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN adds the illegal_instr
// output and a sticky TRAP state for unsupported opcodes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory completes
// DECODE   | ALUOut <= OldPC + imm (branch/jump target), dispatch
// MEMADR   | ALUOut <= rs1 + imm
// MEMREAD  | read data at ALUOut, wait for memory
// MEMWB    | rd <= Data
// MEMWRITE | write rs2 at ALUOut, wait for memory
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BEQ      | compare rs1/rs2, PC <= target when equal
// JAL      | PC <= target, ALUOut <= OldPC + 4
// HALT     | post-reset idle, leaves on first cycle out of reset
// TRAP     | unsupported opcode seen, held until reset
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUCtl,
    output logic       instr_retire
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    localparam state_t RESET_STATE = RESET_STATE_FETCH ? S_FETCH : S_HALT;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    localparam state_t UNSUPPORTED_NEXT = S_TRAP;
    localparam logic   NOP_RETIRE       = 1'b0;
`else
    localparam state_t UNSUPPORTED_NEXT = S_FETCH;
    localparam logic   NOP_RETIRE       = 1'b1;
`endif

    state_t     state_q, state_d;
    logic [1:0] alu_op;

    ALUDecoder u_alu_decoder (
        .ALUOp      (alu_op),
        .funct3     (func3),
        .op5        (opcode[5]),
        .funct7b5   (func7_5),
        .ALUControl (ALUCtl)
    );

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    // Next-state logic; memory states advance only on mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = UNSUPPORTED_NEXT;
                endcase
            end
            S_MEMADR: begin
                if      (opcode == OP_SW) state_d = S_MEMWRITE;
                else if (opcode == OP_LW) state_d = S_MEMREAD;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode; reset forces every strobe and select low.
    always_comb begin
        mem_req      = 1'b0;
        MemWrite     = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        ResultSrc    = RES_ALUOUT;
        ImmSrc       = imm_src(opcode);
        alu_op       = ALUOP_ADD;
        instr_retire = 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_IMM;
                instr_retire = NOP_RETIRE && !op_supported(opcode);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                RegWrite     = 1'b1;
                instr_retire = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req      = 1'b1;
                AdrSrc       = 1'b1;
                MemWrite     = 1'b1;
                instr_retire = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_FUNC;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNC;
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                instr_retire = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_RS2;
                alu_op       = ALUOP_SUB;
                PCWrite      = Zero;
                instr_retire = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_TRAP: illegal_instr = 1'b1;
`endif
            default: ;
        endcase

        if (reset) begin
            mem_req      = 1'b0;
            MemWrite     = 1'b0;
            AdrSrc       = 1'b0;
            IRWrite      = 1'b0;
            PCWrite      = 1'b0;
            RegWrite     = 1'b0;
            ALUSrcA      = SRCA_PC;
            ALUSrcB      = SRCB_RS2;
            ResultSrc    = RES_ALUOUT;
            ImmSrc       = IMM_I;
            alu_op       = ALUOP_ADD;
            instr_retire = 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            illegal_instr = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: steps through each instruction
// class cycle by cycle and compares every control output to hand-written values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b1100011;
    logic [2:0] func3 = 3'd0;
    logic       func7_5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_retire;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0] ALUCtl;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1110011;

    multicycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .func3        (func3),
        .func7_5      (func7_5),
        .Zero         (Zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .MemWrite     (MemWrite),
        .AdrSrc       (AdrSrc),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ResultSrc    (ResultSrc),
        .ImmSrc       (ImmSrc),
        .ALUCtl       (ALUCtl),
        .instr_retire (instr_retire)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ,
        .illegal_instr(illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, drive inputs mid-cycle, settle before checks.
    task automatic cyc(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75, input logic z, input logic rdy);
        @(negedge clk);
        reset = rst; opcode = op; func3 = f3; func7_5 = f75; Zero = z; mem_ready = rdy;
        #1;
    endtask

    // Order: mem_req MemWrite AdrSrc IRWrite PCWrite RegWrite ALUSrcA ALUSrcB ResultSrc instr_retire
    task automatic e(input string tag, input logic req, input logic mw, input logic adr,
                     input logic irw, input logic pcw, input logic rw, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [1:0] rs, input logic ret);
        chk(tag,
            {3'b0, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc, instr_retire},
            {3'b0, req, mw, adr, irw, pcw, rw, sa, sb, rs, ret});
    endtask

    task automatic e_fetch(input string tag);
        e(tag, 1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 0);
    endtask

    task automatic e_decode(input string tag);
        e(tag, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0);
    endtask

    task automatic e_zero(input string tag);
        e(tag, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    endtask

    initial begin
        // reset held, memory ready: nothing may strobe
        for (int i = 0; i < 3; i++) begin
            cyc(1, BEQ, 0, 0, 1, 1);
            e_zero("reset_hold");
        end
        chk("reset_aluctl", {12'b0, ALUCtl}, 16'h0000);

        // beq taken: 3 cycles, first cycle out of reset is FETCH
        cyc(0, BEQ, 0, 0, 1, 1); e_fetch("beq1_fetch");
        cyc(0, BEQ, 0, 0, 1, 1); e_decode("beq1_dec");
        chk("beq_immsrc", {14'b0, ImmSrc}, 16'd2);
        cyc(0, BEQ, 0, 0, 1, 1); e("beq1_taken", 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 1);
        chk("beq_aluctl_sub", {12'b0, ALUCtl}, 16'd1);

        // beq not taken
        cyc(0, BEQ, 0, 0, 0, 1); e_fetch("beq0_fetch");
        cyc(0, BEQ, 0, 0, 0, 1); e_decode("beq0_dec");
        cyc(0, BEQ, 0, 0, 0, 1); e("beq0_nottaken", 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 1);

        // lw with two wait cycles in FETCH and in MEMREAD: 9 cycles
        cyc(0, LW, 3'd2, 0, 0, 0); e("lw_fetch_wait1", 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 0);
        cyc(0, LW, 3'd2, 0, 0, 0); e("lw_fetch_wait2", 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 0);
        cyc(0, LW, 3'd2, 0, 0, 1); e_fetch("lw_fetch_done");
        cyc(0, LW, 3'd2, 0, 0, 1); e_decode("lw_dec");
        chk("lw_immsrc", {14'b0, ImmSrc}, 16'd0);
        cyc(0, LW, 3'd2, 0, 0, 1); e("lw_memadr", 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 0);
        cyc(0, LW, 3'd2, 0, 0, 0); e("lw_rd_wait1", 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        cyc(0, LW, 3'd2, 0, 0, 0); e("lw_rd_wait2", 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        cyc(0, LW, 3'd2, 0, 0, 1); e("lw_rd_done", 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        cyc(0, LW, 3'd2, 0, 0, 1); e("lw_memwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 1);

        // sw, zero wait: MemWrite only in cycle 4
        cyc(0, SW, 3'd2, 0, 0, 1); e_fetch("sw_fetch");
        cyc(0, SW, 3'd2, 0, 0, 1); e_decode("sw_dec");
        chk("sw_immsrc", {14'b0, ImmSrc}, 16'd1);
        cyc(0, SW, 3'd2, 0, 0, 1); e("sw_memadr", 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 0);
        cyc(0, SW, 3'd2, 0, 0, 1); e("sw_memwrite", 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);

        // R-type sub
        cyc(0, RT, 3'd0, 1, 0, 1); e_fetch("sub_fetch");
        cyc(0, RT, 3'd0, 1, 0, 1); e_decode("sub_dec");
        cyc(0, RT, 3'd0, 1, 0, 1); e("sub_execr", 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0);
        chk("sub_aluctl", {12'b0, ALUCtl}, 16'd1);
        cyc(0, RT, 3'd0, 1, 0, 1); e("sub_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1);

        // addi whose immediate has bit 30 set must still add
        cyc(0, IT, 3'd0, 1, 0, 1); e_fetch("addi_fetch");
        cyc(0, IT, 3'd0, 1, 0, 1); e_decode("addi_dec");
        cyc(0, IT, 3'd0, 1, 0, 1); e("addi_execi", 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 0);
        chk("addi_aluctl", {12'b0, ALUCtl}, 16'd0);
        cyc(0, IT, 3'd5, 1, 0, 1); chk("srai_aluctl_wb_state", {12'b0, ALUCtl}, 16'd0);
        e("addi_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1);

        // srai via EXECI
        cyc(0, IT, 3'd5, 1, 0, 1); e_fetch("srai_fetch");
        cyc(0, IT, 3'd5, 1, 0, 1); e_decode("srai_dec");
        cyc(0, IT, 3'd5, 1, 0, 1); chk("srai_aluctl", {12'b0, ALUCtl}, 16'd8);
        cyc(0, IT, 3'd5, 1, 0, 1); e("srai_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1);

        // jal: PCWrite in JAL, RegWrite in ALUWB
        cyc(0, JAL, 3'd0, 0, 0, 1); e_fetch("jal_fetch");
        cyc(0, JAL, 3'd0, 0, 0, 1); e_decode("jal_dec");
        chk("jal_immsrc", {14'b0, ImmSrc}, 16'd3);
        cyc(0, JAL, 3'd0, 0, 0, 1); e("jal_jal", 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 0);
        cyc(0, JAL, 3'd0, 0, 0, 1); e("jal_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1);

        // sw stalled in MEMWRITE, then reset: MemWrite drops the same cycle
        cyc(0, SW, 3'd2, 0, 0, 1); e_fetch("swr_fetch");
        cyc(0, SW, 3'd2, 0, 0, 1); e_decode("swr_dec");
        cyc(0, SW, 3'd2, 0, 0, 1); e("swr_memadr", 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 0);
        cyc(0, SW, 3'd2, 0, 0, 0); e("swr_wait", 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        cyc(1, SW, 3'd2, 0, 0, 0); e_zero("swr_reset");
        cyc(0, BAD, 3'd0, 0, 0, 1); e_fetch("swr_refetch");

        // unsupported opcode
        cyc(0, BAD, 3'd0, 0, 0, 1);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        e_decode("bad_dec");
        chk("bad_illegal_dec", {15'b0, illegal_instr}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, BAD, 3'd0, 0, 0, 1);
            e_zero("trap_hold");
            chk("trap_illegal", {15'b0, illegal_instr}, 16'd1);
        end
        cyc(1, BAD, 3'd0, 0, 0, 1); e_zero("trap_reset");
        chk("trap_reset_illegal", {15'b0, illegal_instr}, 16'd0);
        cyc(0, BEQ, 3'd0, 0, 0, 1); e_fetch("trap_refetch");
`else
        e("bad_nop_retire", 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 1);
        cyc(0, BEQ, 3'd0, 0, 0, 1); e_fetch("bad_refetch");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
